axil_cfg_sequencer: RTL

Hardware replacement for the testbench register-access tasks. It accepts register commands (WRITE, READ, POLL) from a command stream and executes each as a single-beat AXI4 transaction on one accelerator slave port. Each command returns one response carrying read data and error status. It sits between a boot/config command source (ROM walker or host FIFO) and the accelerator's s_axi configuration port.

---
 rtl/axil_cfg_pkg.sv | 30 +++
 rtl/axil_cfg_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cfg_pkg.sv
// Shared types and AXI constants for the AXI4-Lite style register command sequencer.
package axil_cfg_pkg;

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_READ  = 2'd1,
      OP_POLL  = 2'd2
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WR_REQ    = 3'd1,
      ST_WR_RESP   = 3'd2,
      ST_RD_REQ    = 3'd3,
      ST_RD_DATA   = 3'd4,
      ST_POLL_WAIT = 3'd5,
      ST_RESP      = 3'd6
   } state_e;

   localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   function automatic logic poll_match(input logic [31:0] rdata,
                                       input logic [31:0] expect_val,
                                       input logic [31:0] mask);
      return ((rdata ^ expect_val) & mask) == 32'd0;
   endfunction

endpackage

// File: rtl/axil_cfg_sequencer.sv
// Executes WRITE/READ/POLL register commands as single-beat AXI4 transactions
// and returns one response per command.
module axil_cfg_sequencer
   import axil_cfg_pkg::*;
#(
   parameter int ADDR_WIDTH = 40,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 6,
   parameter int AXI_ID     = 1,
   parameter int POLL_GAP   = 4,
   parameter int POLL_MAX   = 1024
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic [1:0]                      cmd_op,
   input  logic [ADDR_WIDTH-1:0]           cmd_addr,
   input  logic [DATA_WIDTH-1:0]           cmd_data,
   input  logic [DATA_WIDTH-1:0]           cmd_mask,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic [DATA_WIDTH-1:0]           rsp_data,
   output logic                            rsp_err,
   output logic                            rsp_timeout,
   output logic [$clog2(POLL_MAX+1)-1:0]   rsp_polls,
   output logic                            busy,
   output logic [ID_WIDTH-1:0]             s_axi_awid,
   output logic [ADDR_WIDTH-1:0]           s_axi_awaddr,
   output logic [7:0]                      s_axi_awlen,
   output logic [2:0]                      s_axi_awsize,
   output logic [1:0]                      s_axi_awburst,
   output logic                            s_axi_awlock,
   output logic [3:0]                      s_axi_awcache,
   output logic [2:0]                      s_axi_awprot,
   output logic                            s_axi_awvalid,
   input  logic                            s_axi_awready,
   output logic [DATA_WIDTH-1:0]           s_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]         s_axi_wstrb,
   output logic                            s_axi_wlast,
   output logic                            s_axi_wvalid,
   input  logic                            s_axi_wready,
   input  logic [ID_WIDTH-1:0]             s_axi_bid,
   input  logic [1:0]                      s_axi_bresp,
   input  logic                            s_axi_bvalid,
   output logic                            s_axi_bready,
   output logic [ID_WIDTH-1:0]             s_axi_arid,
   output logic [ADDR_WIDTH-1:0]           s_axi_araddr,
   output logic [7:0]                      s_axi_arlen,
   output logic [2:0]                      s_axi_arsize,
   output logic [1:0]                      s_axi_arburst,
   output logic                            s_axi_arlock,
   output logic [3:0]                      s_axi_arcache,
   output logic [2:0]                      s_axi_arprot,
   output logic                            s_axi_arvalid,
   input  logic                            s_axi_arready,
   input  logic [ID_WIDTH-1:0]             s_axi_rid,
   input  logic [DATA_WIDTH-1:0]           s_axi_rdata,
   input  logic [1:0]                      s_axi_rresp,
   input  logic                            s_axi_rlast,
   input  logic                            s_axi_rvalid,
   output logic                            s_axi_rready
);

   localparam int PW = $clog2(POLL_MAX + 1);
   localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
   localparam logic [PW-1:0] POLL_LIMIT = PW'(POLL_MAX);
   localparam logic [GW-1:0] GAP_LAST   = (POLL_GAP > 0) ? GW'(POLL_GAP - 1) : {GW{1'b0}};

   state_e                  state_r, next_state_s;
   op_e                     op_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [DATA_WIDTH-1:0]   data_r, mask_r, rsp_data_r;
   logic [PW-1:0]           poll_cnt_r, poll_inc_s;
   logic [GW-1:0]           gap_cnt_r;
   logic                    aw_done_r, w_done_r, rsp_err_r, rsp_timeout_r;
   logic                    r_err_s, match_s, poll_last_s, timeout_s;
   logic                    unused_s;

   assign poll_inc_s  = poll_cnt_r + {{(PW-1){1'b0}}, 1'b1};
   assign r_err_s     = (s_axi_rresp != AXI_RESP_OKAY);
   assign match_s     = poll_match(s_axi_rdata, data_r, mask_r);
   assign poll_last_s = (poll_inc_s == POLL_LIMIT);
   assign timeout_s   = (op_r == OP_POLL) & ~r_err_s & ~match_s & poll_last_s;
   assign unused_s    = ^{s_axi_bid, s_axi_rid, s_axi_rlast};

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // next-state decode
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               next_state_s = (cmd_op == OP_WRITE) ? ST_WR_REQ : ST_RD_REQ;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_WR_REQ: begin
            if ((aw_done_r | s_axi_awready) & (w_done_r | s_axi_wready)) begin
               next_state_s = ST_WR_RESP;
            end else begin
               next_state_s = ST_WR_REQ;
            end
         end
         ST_WR_RESP: begin
            if (s_axi_bvalid) begin
               next_state_s = ST_RESP;
            end else begin
               next_state_s = ST_WR_RESP;
            end
         end
         ST_RD_REQ: begin
            if (s_axi_arready) begin
               next_state_s = ST_RD_DATA;
            end else begin
               next_state_s = ST_RD_REQ;
            end
         end
         ST_RD_DATA: begin
            if (!s_axi_rvalid) begin
               next_state_s = ST_RD_DATA;
            end else if ((op_r != OP_POLL) || r_err_s || match_s || poll_last_s) begin
               next_state_s = ST_RESP;
            end else if (POLL_GAP == 0) begin
               next_state_s = ST_RD_REQ;
            end else begin
               next_state_s = ST_POLL_WAIT;
            end
         end
         ST_POLL_WAIT: begin
            if (gap_cnt_r == GAP_LAST) begin
               next_state_s = ST_RD_REQ;
            end else begin
               next_state_s = ST_POLL_WAIT;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_RESP;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // command latch, handshake tracking, poll counters and response fields
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r          <= OP_WRITE;
         addr_r        <= {ADDR_WIDTH{1'b0}};
         data_r        <= {DATA_WIDTH{1'b0}};
         mask_r        <= {DATA_WIDTH{1'b0}};
         poll_cnt_r    <= {PW{1'b0}};
         gap_cnt_r     <= {GW{1'b0}};
         aw_done_r     <= 1'b0;
         w_done_r      <= 1'b0;
         rsp_data_r    <= {DATA_WIDTH{1'b0}};
         rsp_err_r     <= 1'b0;
         rsp_timeout_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_r          <= (cmd_op == OP_POLL)  ? OP_POLL :
                                   (cmd_op == OP_WRITE) ? OP_WRITE : OP_READ;
                  addr_r        <= cmd_addr;
                  data_r        <= cmd_data;
                  mask_r        <= cmd_mask;
                  poll_cnt_r    <= {PW{1'b0}};
                  aw_done_r     <= 1'b0;
                  w_done_r      <= 1'b0;
                  rsp_data_r    <= {DATA_WIDTH{1'b0}};
                  rsp_err_r     <= 1'b0;
                  rsp_timeout_r <= 1'b0;
               end
            end
            ST_WR_REQ: begin
               if (s_axi_awready) aw_done_r <= 1'b1;
               if (s_axi_wready)  w_done_r  <= 1'b1;
            end
            ST_WR_RESP: begin
               if (s_axi_bvalid) rsp_err_r <= (s_axi_bresp != AXI_RESP_OKAY);
            end
            ST_RD_DATA: begin
               if (s_axi_rvalid) begin
                  rsp_data_r    <= s_axi_rdata;
                  poll_cnt_r    <= poll_inc_s;
                  gap_cnt_r     <= {GW{1'b0}};
                  rsp_err_r     <= r_err_s | timeout_s;
                  rsp_timeout_r <= timeout_s;
               end
            end
            ST_POLL_WAIT: gap_cnt_r <= gap_cnt_r + {{(GW-1){1'b0}}, 1'b1};
            default: ;
         endcase
      end
   end

   assign cmd_ready   = (state_r == ST_IDLE) & ~rst;
   assign busy        = (state_r != ST_IDLE);
   assign rsp_valid   = (state_r == ST_RESP);
   assign rsp_data    = rsp_data_r;
   assign rsp_err     = rsp_err_r;
   assign rsp_timeout = rsp_timeout_r;
   assign rsp_polls   = poll_cnt_r;

   // AW and W drop independently once their own handshake is recorded
   assign s_axi_awvalid = (state_r == ST_WR_REQ) & ~aw_done_r;
   assign s_axi_wvalid  = (state_r == ST_WR_REQ) & ~w_done_r;
   assign s_axi_bready  = (state_r == ST_WR_RESP);
   assign s_axi_arvalid = (state_r == ST_RD_REQ);
   assign s_axi_rready  = (state_r == ST_RD_DATA);

   assign s_axi_awid    = ID_WIDTH'(AXI_ID);
   assign s_axi_awaddr  = addr_r;
   assign s_axi_awlen   = 8'd0;
   assign s_axi_awsize  = AXI_SIZE_4B;
   assign s_axi_awburst = AXI_BURST_INCR;
   assign s_axi_awlock  = 1'b0;
   assign s_axi_awcache = 4'd0;
   assign s_axi_awprot  = 3'd0;
   assign s_axi_wdata   = data_r;
   assign s_axi_wstrb   = {(DATA_WIDTH/8){1'b1}};
   assign s_axi_wlast   = 1'b1;
   assign s_axi_arid    = ID_WIDTH'(AXI_ID);
   assign s_axi_araddr  = addr_r;
   assign s_axi_arlen   = 8'd0;
   assign s_axi_arsize  = AXI_SIZE_4B;
   assign s_axi_arburst = AXI_BURST_INCR;
   assign s_axi_arlock  = 1'b0;
   assign s_axi_arcache = 4'd0;
   assign s_axi_arprot  = 3'd0;

endmodule
